pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds what the plain stage registers lack: valid/ready back-pressure, a synchronous flush, and an optional 2-entry skid buffer.
- With the skid buffer, o_ready is fully registered, so the upstream ready path has no combinational dependency on i_ready.
- Payload is an opaque DATA_W-bit vector. Each stage packs its own fields (pc, instruction, rd, control bits) into it.

Parameters:
- DATA_W, 32: payload width in bits (>=1).
- RST_DATA, 0: payload value loaded on reset. MEM/WB instances set the instruction field to a NOP encoding, 0x00000013.
- SKID, 1: 1 = two-entry skid buffer with registered o_ready; 0 = single register with o_ready = i_ready | ~o_valid.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_flush  in  1  synchronous kill of all held entries.
- i_valid  in  1  upstream payload valid.
- o_ready  out  1  stage can accept this cycle.
- i_data  in  DATA_W  upstream payload.
- o_valid  out  1  downstream payload valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_W  payload to downstream.
- o_occ  out  2  entries held (0..2; max 1 when SKID=0).
- o_stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Clock and reset:
  - Clock is i_clk.
  - Reset is i_rst, synchronous, active-high.
  - On reset: o_valid=0, o_data=RST_DATA, skid entry invalid, skid data=RST_DATA, o_occ=0, o_stall_cnt=0.
  - o_ready=1 on the first cycle after reset.
- Handshake rules:
  - Input transfer occurs when i_valid & o_ready.
  - Output transfer occurs when o_valid & i_ready.
  - o_data is held stable while o_valid & ~i_ready.
- SKID=1 state machine (o_ready = (state != FULL), registered):
  - EMPTY: input transfer -> BUSY, main <= i_data. Latency 1 cycle.
  - BUSY:
    - input only -> FULL, skid <= i_data.
    - output only -> EMPTY.
    - both -> BUSY, main <= i_data.
    - neither -> BUSY.
  - FULL:
    - output transfer -> BUSY, main <= skid.
    - otherwise stay in FULL. No input is possible since o_ready=0.
- SKID=0:
  - One entry; o_ready is combinational: i_ready | ~o_valid.
  - Input transfer loads main and sets o_valid.
  - Output transfer without input clears o_valid.
- Ordering:
  - Strict FIFO order; no entry is duplicated or dropped except by flush.
  - Throughput is 1 transfer/cycle when i_ready is held high.
- Flush:
  - i_flush=1 -> next state EMPTY, o_valid=0, o_occ=0.
  - Data registers retain their values (don't-care).
  - Flush has priority over a simultaneous input transfer; that payload is discarded.
  - An output transfer in the flush cycle still counts as delivered.
- Priority order: i_rst > i_flush > handshake.
- Reset mid-stall: all entries are discarded; no output transfer follows.
- o_occ encoding: EMPTY=0, BUSY=1, FULL=2.

Optional Feature:
- Macro: PIPE_SKID_STAGE_STALL_CNT_EN.
- Defined:
  - o_stall_cnt increments each cycle that o_valid & ~i_ready.
  - Saturates at 0xFFFFFFFF.
  - Cleared by i_rst only; not cleared by flush.
- Undefined: o_stall_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package pipe_pkg:
  - state enum (EMPTY, BUSY, FULL) with 2-bit encoding matching o_occ.
  - constant NOP_INSN = 32'h00000013.
  - localparam for stall-counter width (32).
- Sub-module pipe_slot: one DATA_W register with load enable and reset value. Instantiated as main (always) and skid (SKID=1 only, via generate).

Test Plan:
- Streaming: SKID=1, i_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> o_data 0x11,0x22,0x33 one cycle later each; o_occ stays 1; o_ready stays 1.
- Back-pressure: push 0xA, 0xB, 0xC continuously with i_ready=0.
  - o_occ goes 1 then 2; o_ready=0 after the second accept; 0xC is held upstream.
  - Raise i_ready -> output 0xA, 0xB, 0xC in order, none lost.
- Flush while FULL: hold 0xA, 0xB, then i_flush=1 with i_valid=1 and data 0xD.
  - Next cycle: o_valid=0, o_occ=0, o_ready=1; 0xD never appears.
- Reset: assert i_rst mid-stall with RST_DATA=0x13.
  - Next cycle: o_valid=0, o_data=0x13, o_occ=0, o_ready=1, o_stall_cnt=0.
- SKID=0: i_ready=0 with one entry held -> o_ready=0 combinationally; i_ready=1 with i_valid=1 in the same cycle -> o_ready=1 and the entry is replaced in one cycle.
- With PIPE_SKID_STAGE_STALL_CNT_EN defined: hold o_valid=1, i_ready=0 for 5 cycles -> o_stall_cnt=5; i_flush leaves it at 5. Without the macro it reads 0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and constants for pipeline stage registers
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    localparam logic [31:0] NOP_INSN = 32'h00000013;
    localparam int STALL_W = 32;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register with load enable and reset value
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);
    always_ff @(posedge i_clk) begin
        if (i_rst) o_q <= RST_DATA;
        else if (i_ld) o_q <= i_d;
    end
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage with flush and optional 2-entry skid buffer
// PIPE_SKID_STAGE_STALL_CNT_EN adds a saturating stall-cycle counter on o_stall_cnt.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] RST_DATA = '0,
    parameter bit SKID = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_data,
    output logic [1:0]         o_occ,
    output logic [STALL_W-1:0] o_stall_cnt
);
    state_t st, st_nxt;
    logic in_xfer, out_xfer, ld_main, ld_skid;
    logic [DATA_W-1:0] main_d, skid_q;
    assign o_valid = st != EMPTY;
    // With SKID the ready is a pure function of the state register.
    assign o_ready = SKID ? st != FULL : (i_ready | ~o_valid);
    assign o_occ = st;
    assign in_xfer = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;
    always_ff @(posedge i_clk) begin
        st <= i_rst ? EMPTY : st_nxt;
    end
    always_comb begin
        st_nxt = st;
        ld_main = 1'b0;
        ld_skid = 1'b0;
        main_d = i_data;
        if (i_flush) st_nxt = EMPTY;
        else case (st)
            EMPTY: begin
                st_nxt = in_xfer ? BUSY : EMPTY;
                ld_main = in_xfer;
            end
            BUSY: begin
                st_nxt = in_xfer && !out_xfer ? FULL : !in_xfer && out_xfer ? EMPTY : BUSY;
                ld_main = in_xfer & out_xfer;
                ld_skid = in_xfer & ~out_xfer;
            end
            FULL: begin
                st_nxt = out_xfer ? BUSY : FULL;
                ld_main = out_xfer;
                main_d = skid_q;
            end
            default: st_nxt = EMPTY;
        endcase
    end
    pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_main (
        .i_clk(i_clk), .i_rst(i_rst), .i_ld(ld_main), .i_d(main_d), .o_q(o_data)
    );
    generate
        if (SKID) begin : g_skid
            pipe_slot #(.DATA_W(DATA_W), .RST_DATA(RST_DATA)) u_skid (
                .i_clk(i_clk), .i_rst(i_rst), .i_ld(ld_skid), .i_d(i_data), .o_q(skid_q)
            );
        end else begin : g_noskid
            assign skid_q = RST_DATA;
        end
    endgenerate
`ifdef PIPE_SKID_STAGE_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) stall_q <= '0;
        else if (o_valid && !i_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: queue-model scoreboard for SKID=1 and SKID=0 instances sharing one stimulus
module tb_pipe_skid_stage;
    logic clk = 1'b0;
    logic i_rst, i_flush, i_valid, i_ready;
    logic [31:0] i_data;
    logic ov [2];
    logic ordy [2];
    logic [31:0] od [2];
    logic [1:0] oc [2];
    logic [31:0] sc [2];
    logic [31:0] q [2][$];
    logic [31:0] rst_val [2];
    logic [31:0] stall [2];
    logic fresh [2];
    logic rdy [2];
    logic stall_inc [2];
    logic chk_en = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(32), .RST_DATA(32'h13), .SKID(1)) u_skid1 (
        .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy[0]),
        .i_data(i_data), .o_valid(ov[0]), .i_ready(i_ready), .o_data(od[0]), .o_occ(oc[0]),
        .o_stall_cnt(sc[0])
    );
    pipe_skid_stage #(.DATA_W(32), .RST_DATA(32'h0), .SKID(0)) u_skid0 (
        .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(ordy[1]),
        .i_data(i_data), .o_valid(ov[1]), .i_ready(i_ready), .o_data(od[1]), .o_occ(oc[1]),
        .o_stall_cnt(sc[1])
    );

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor: every output transfer must deliver the oldest expected payload.
    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            if (chk_en && !i_rst && ov[k] && i_ready) begin
                if (q[k].size() == 0) chk("unexpected_output", k, od[k], 32'hxxxxxxxx);
                else chk("out_data", k, od[k], q[k].pop_front());
            end
        end
    end

    // Capacity is 2 with the skid buffer; a single register passes through when downstream is ready.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f, input logic rs);
        @(negedge clk);
        i_valid = v;
        i_data = d;
        i_ready = r;
        i_flush = f;
        i_rst = rs;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy[k] = (k == 0) ? (q[k].size() < 2) : (r || q[k].size() == 0);
            stall_inc[k] = q[k].size() != 0 && !r;
            if (chk_en) begin
                chk("o_valid", k, 32'(ov[k]), 32'(q[k].size() != 0));
                chk("o_ready", k, 32'(ordy[k]), 32'(rdy[k]));
                chk("o_occ", k, 32'(oc[k]), 32'(q[k].size()));
                chk("o_stall_cnt", k, sc[k], stall[k]);
                if (q[k].size() != 0) chk("o_data_head", k, od[k], q[k][0]);
                else if (fresh[k]) chk("o_data_rst", k, od[k], rst_val[k]);
            end
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                q[k].delete();
                fresh[k] = 1'b1;
                stall[k] = 0;
            end else begin
`ifdef PIPE_SKID_STAGE_STALL_CNT_EN
                if (stall_inc[k] && stall[k] != 32'hFFFFFFFF) stall[k] = stall[k] + 1;
`endif
                if (f) begin
                    q[k].delete();
                    fresh[k] = 1'b0;
                end else if (v && rdy[k]) begin
                    q[k].push_back(d);
                    fresh[k] = 1'b0;
                end
            end
        end
        chk_en = 1'b1;
    endtask

    initial begin
        rst_val[0] = 32'h13;
        rst_val[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            stall[k] = 0;
            fresh[k] = 1'b1;
        end
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        // streaming
        cyc(1, 32'h11, 1, 0, 0);
        cyc(1, 32'h22, 1, 0, 0);
        cyc(1, 32'h33, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        // back-pressure then drain
        cyc(1, 32'hA, 0, 0, 0);
        cyc(1, 32'hB, 0, 0, 0);
        cyc(1, 32'hC, 0, 0, 0);
        cyc(1, 32'hC, 0, 0, 0);
        cyc(1, 32'hC, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        // flush while full with a competing input
        cyc(1, 32'hA, 0, 0, 0);
        cyc(1, 32'hB, 0, 0, 0);
        cyc(1, 32'hD, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        // stall run, flush, then reset mid-stall
        cyc(1, 32'h55, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h66, 0, 0, 0);
        cyc(1, 32'h77, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        repeat (4000)
            cyc($urandom_range(9) < 7, $urandom, $urandom_range(9) < 6,
                $urandom_range(24) == 0, $urandom_range(299) == 0);
        repeat (4) cyc(0, 0, 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
